// File: rtl/draw_glyph_object.sv
// Draws one 8x8 glyph from a synchronous glyph ROM as one VGA pixel write per cycle; 82 cycles per glyph.
// Optional macro DRAW_TRANSPARENT_EN: clear bitmap bits skip the write instead of painting BG_COLOUR.
module draw_glyph_object #(
    parameter logic [8:0] FG_COLOUR = 9'h1FF,
    parameter logic [8:0] BG_COLOUR = 9'h000,
    parameter int         SCREEN_W  = 320,
    parameter int         SCREEN_H  = 240
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_draw,
    input  logic [8:0] x_in,
    input  logic [7:0] y_in,
    input  logic [4:0] glyph_type,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       plot,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [8:0] colour,
    output logic       draw_object_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        DRAW,
        DONE,
        WAIT_RELEASE
    } state_t;

    localparam logic [9:0] X_LIM = SCREEN_W[9:0];
    localparam logic [8:0] Y_LIM = SCREEN_H[8:0];

    state_t     state;
    logic [8:0] x_l;
    logic [7:0] y_l;
    logic [4:0] glyph_l;
    logic [2:0] row;
    logic [2:0] col;
    logic [6:0] bits;

    logic [2:0] nxt_col;
    logic       nxt_bit;
    logic [9:0] x_sum;
    logic [8:0] y_sum;
    logic       in_screen;
    logic       pix_plot;
    logic [8:0] pix_colour;

    // Outputs are registered, so each cycle prepares the pixel shown in the next one.
    always_comb begin
        nxt_col    = (state == DRAW) ? col + 3'd1 : 3'd0;
        nxt_bit    = (state == DRAW) ? bits[6] : rom_data[7];
        x_sum      = {1'b0, x_l} + {7'd0, nxt_col};
        y_sum      = {1'b0, y_l} + {6'd0, row};
        in_screen  = (x_sum < X_LIM) && (y_sum < Y_LIM);
`ifdef DRAW_TRANSPARENT_EN
        pix_plot   = in_screen && nxt_bit;
        pix_colour = FG_COLOUR;
`else
        pix_plot   = in_screen;
        pix_colour = nxt_bit ? FG_COLOUR : BG_COLOUR;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= IDLE;
            x_l              <= '0;
            y_l              <= '0;
            glyph_l          <= '0;
            row              <= '0;
            col              <= '0;
            bits             <= '0;
            rom_addr         <= '0;
            plot             <= 1'b0;
            vga_x            <= '0;
            vga_y            <= '0;
            colour           <= '0;
            draw_object_done <= 1'b0;
            busy             <= 1'b0;
        end else begin
            plot             <= 1'b0;
            draw_object_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_draw) begin
                        x_l      <= x_in;
                        y_l      <= y_in;
                        glyph_l  <= glyph_type;
                        row      <= 3'd0;
                        col      <= 3'd0;
                        rom_addr <= {glyph_type, 3'd0};
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    state <= WAIT_ROM;
                end
                WAIT_ROM: begin
                    bits   <= rom_data[6:0];
                    col    <= 3'd0;
                    plot   <= pix_plot;
                    vga_x  <= x_sum[8:0];
                    vga_y  <= y_sum[7:0];
                    colour <= pix_colour;
                    state  <= DRAW;
                end
                DRAW: begin
                    if (col == 3'd7) begin
                        if (row == 3'd7) begin
                            draw_object_done <= 1'b1;
                            state            <= DONE;
                        end else begin
                            row      <= row + 3'd1;
                            col      <= 3'd0;
                            rom_addr <= {glyph_l, row + 3'd1};
                            state    <= FETCH;
                        end
                    end else begin
                        col    <= col + 3'd1;
                        bits   <= {bits[5:0], 1'b0};
                        plot   <= pix_plot;
                        vga_x  <= x_sum[8:0];
                        vga_y  <= y_sum[7:0];
                        colour <= pix_colour;
                    end
                end
                DONE: begin
                    if (start_draw) begin
                        state <= WAIT_RELEASE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT_RELEASE: begin
                    // A request still held from the finished draw must not start another one.
                    if (!start_draw) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_glyph_object.sv
// Directed bench for draw_glyph_object: per-cycle expectations derived from the glyph timing and clipping rules.
module tb_draw_glyph_object;

`ifdef DRAW_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif
    localparam logic [8:0] FG = 9'h1FF;
    localparam logic [8:0] BG = 9'h000;

    logic       clk;
    logic       resetn;
    logic       start_draw;
    logic [8:0] x_in;
    logic [7:0] y_in;
    logic [4:0] glyph_type;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       plot;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [8:0] colour;
    logic       draw_object_done;
    logic       busy;
    logic [7:0] rom_row;

    int checks = 0;
    int passed = 0;
    int n_plot;
    int n_fg;

    draw_glyph_object dut (
        .clk              (clk),
        .resetn           (resetn),
        .start_draw       (start_draw),
        .x_in             (x_in),
        .y_in             (y_in),
        .glyph_type       (glyph_type),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .plot             (plot),
        .vga_x            (vga_x),
        .vga_y            (vga_y),
        .colour           (colour),
        .draw_object_done (draw_object_done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Every row of the glyph ROM holds the same pattern; the address is checked separately.
    always @(posedge clk) rom_data <= rom_row;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues a request and checks cycles 1..81; returns at the negedge of cycle 81 with start still high.
    task automatic run_glyph(input int x, input int y, input int t, input logic [7:0] pat,
                             input bit mid, output int np, output int nfg);
        int r, c, fr, ex, ey;
        bit in_draw, bitv, inb, exp_plot;
        x_in = 9'(x);
        y_in = 8'(y);
        glyph_type = 5'(t);
        rom_row = pat;
        start_draw = 1'b1;
        np = 0;
        nfg = 0;
        @(posedge clk);
        for (int k = 1; k <= 81; k++) begin
            @(negedge clk);
            r  = (k - 3) / 10;
            c  = (k - 3) % 10;
            fr = (k - 1) / 10;
            in_draw = (k >= 3) && (c < 8);
            if (in_draw) begin
                ex = x + c;
                ey = y + r;
                bitv = pat[7 - c];
                inb = (ex < 320) && (ey < 240);
                exp_plot = inb && (TRANSP ? bitv : 1'b1);
                chk("plot", 32'(plot), 32'(exp_plot));
                chk("vga_x", 32'(vga_x), 32'(ex % 512));
                chk("vga_y", 32'(vga_y), 32'(ey % 256));
                if (exp_plot) chk("colour", 32'(colour), 32'(bitv ? FG : BG));
                if (plot) begin
                    np++;
                    if (colour == FG) nfg++;
                end
            end else begin
                chk("plot_gap", 32'(plot), 32'd0);
            end
            if (((k - 1) % 10 == 0) && (k <= 71))
                chk("rom_addr", 32'(rom_addr), 32'(t * 8 + fr));
            chk("done", 32'(draw_object_done), 32'(k == 81));
            chk("busy", 32'(busy), 32'd1);
            if (mid && k == 20) begin
                x_in = 9'd0;
                y_in = 8'd0;
                glyph_type = 5'd0;
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        resetn = 1'b0;
        start_draw = 1'b0;
        x_in = '0;
        y_in = '0;
        glyph_type = '0;
        rom_row = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(draw_object_done), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_vga_x", 32'(vga_x), 32'd0);
        chk("rst_vga_y", 32'(vga_y), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic glyph with columns 0 and 7 set
        run_glyph(98, 97, 31, 8'h81, 1'b0, n_plot, n_fg);
        chk("basic_plots", 32'(n_plot), TRANSP ? 32'd16 : 32'd64);
        chk("basic_fg", 32'(n_fg), 32'd16);

        // Held request: stays parked, no second draw
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_busy", 32'(busy), 32'd1);
            chk("held_plot", 32'(plot), 32'd0);
            chk("held_done", 32'(draw_object_done), 32'd0);
        end
        start_draw = 1'b0;
        @(negedge clk);
        chk("release_busy", 32'(busy), 32'd0);
        run_glyph(10, 20, 23, 8'h3C, 1'b0, n_plot, n_fg);
        chk("t23_plots", 32'(n_plot), TRANSP ? 32'd32 : 32'd64);
        chk("t23_fg", 32'(n_fg), 32'd32);
        start_draw = 1'b0;
        @(negedge clk);

        // Clipping at the bottom-right corner
        run_glyph(316, 236, 4, 8'hFF, 1'b0, n_plot, n_fg);
        chk("clip_plots", 32'(n_plot), 32'd16);
        start_draw = 1'b0;
        @(negedge clk);

        // Alternating pattern
        run_glyph(100, 50, 9, 8'hAA, 1'b0, n_plot, n_fg);
        chk("aa_plots", 32'(n_plot), TRANSP ? 32'd32 : 32'd64);
        chk("aa_fg", 32'(n_fg), 32'd32);
        start_draw = 1'b0;
        @(negedge clk);

        // Inputs change after latching
        run_glyph(50, 60, 5, 8'h81, 1'b1, n_plot, n_fg);
        chk("mid_fg", 32'(n_fg), 32'd16);
        start_draw = 1'b0;
        @(negedge clk);

        // Reset in cycle 40 of a draw
        x_in = 9'd40;
        y_in = 8'd30;
        glyph_type = 5'd7;
        rom_row = 8'hFF;
        start_draw = 1'b1;
        @(posedge clk);
        repeat (39) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        start_draw = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            chk("abort_plot", 32'(plot), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(draw_object_done), 32'd0);
            @(negedge clk);
        end
        run_glyph(0, 0, 1, 8'hAA, 1'b0, n_plot, n_fg);
        chk("post_rst_plots", 32'(n_plot), TRANSP ? 32'd32 : 32'd64);
        start_draw = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
